// File: rtl/msrv32_lsu_bus_ctrl_if.sv
// Data-memory request/acknowledge bus between the MSRV32 load/store unit and memory.
interface msrv32_lsu_bus_ctrl_if;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [3:0]  dmem_wr_mask_out;
  logic        dmem_ack_in;
  logic [31:0] dmem_rdata_in;

  modport master (
    output dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_wr_mask_out,
    input  dmem_ack_in, dmem_rdata_in
  );

  modport slave (
    input  dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_wr_mask_out,
    output dmem_ack_in, dmem_rdata_in
  );
endinterface

// File: rtl/msrv32_lsu_bus_ctrl.sv
// MSRV32 load/store bus controller: one outstanding request, stalls the pipeline until ack.
// Optional bus timeout is enabled by defining MSRV32_LSU_TIMEOUT_EN.
module msrv32_lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                         ms_risc32_mp_clk_in,
  input  logic                         ms_risc32_mp_rst_in,
  input  logic                         mem_req_in,
  input  logic                         mem_we_in,
  input  logic [1:0]                   load_size_in,
  input  logic                         load_unsigned_in,
  input  logic [31:0]                  addr_in,
  input  logic [31:0]                  store_data_in,
  input  logic                         flush_in,
  msrv32_lsu_bus_ctrl_if.master        dmem,
  output logic                         stall_out,
  output logic [31:0]                  lsu_data_out,
  output logic                         lsu_valid_out,
  output logic                         misaligned_out,
  output logic                         bus_err_out
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_off;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;

  logic        w_misaligned;
  logic        w_accept;
  logic        w_mis_evt;
  logic        w_done;
  logic        w_timeout;

  function automatic logic [3:0] f_store_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   f_store_mask = 4'b0001 << off;
      2'b01:   f_store_mask = off[1] ? 4'b1100 : 4'b0011;
      default: f_store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_store_lanes(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   f_store_lanes = {4{d[7:0]}};
      2'b01:   f_store_lanes = {2{d[15:0]}};
      default: f_store_lanes = d;
    endcase
  endfunction

  function automatic logic [31:0] f_load_extract(input logic [1:0] size, input logic uns,
                                                 input logic [1:0] off, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   f_load_extract = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   f_load_extract = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: f_load_extract = rdata;
    endcase
  endfunction

  assign w_misaligned = ((load_size_in == 2'b01) & addr_in[0]) |
                        (load_size_in[1] & (addr_in[1:0] != 2'b00));
  assign w_accept     = (r_state == S_IDLE) & mem_req_in & ~flush_in & ~w_misaligned;
  assign w_mis_evt    = (r_state == S_IDLE) & mem_req_in & ~flush_in & w_misaligned;
  assign w_done       = (r_state == S_BUSY) & dmem.dmem_ack_in;

`ifdef MSRV32_LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  // Counts BUSY cycles without ack; an ack on the expiring cycle still wins.
  always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
    if (ms_risc32_mp_rst_in) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == S_BUSY) && !dmem.dmem_ack_in) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign w_timeout = (r_state == S_BUSY) & ~dmem.dmem_ack_in &
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
    if (ms_risc32_mp_rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_BUSY;
        else          w_next_state = S_IDLE;
      end
      S_BUSY: begin
        if (w_done || w_timeout) w_next_state = S_IDLE;
        else                     w_next_state = S_BUSY;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs; request follows the state register so reset drops it at once
  always_comb begin
    stall_out         = w_accept | ((r_state == S_BUSY) & ~dmem.dmem_ack_in & ~w_timeout);
    dmem.dmem_req_out = (r_state == S_BUSY);
  end

  assign dmem.dmem_we_out      = r_we;
  assign dmem.dmem_addr_out    = r_addr;
  assign dmem.dmem_wdata_out   = r_wdata;
  assign dmem.dmem_wr_mask_out = r_mask;

  // Request capture, load return data and status pulses
  always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
    if (ms_risc32_mp_rst_in) begin
      r_we           <= 1'b0;
      r_size         <= 2'b00;
      r_unsigned     <= 1'b0;
      r_off          <= 2'b00;
      r_addr         <= 32'h0000_0000;
      r_wdata        <= 32'h0000_0000;
      r_mask         <= 4'b0000;
      lsu_data_out   <= 32'h0000_0000;
      lsu_valid_out  <= 1'b0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;
    end else begin
      lsu_valid_out  <= w_done & ~r_we;
      misaligned_out <= w_mis_evt;
      bus_err_out    <= w_timeout;
      if (w_accept) begin
        r_we       <= mem_we_in;
        r_size     <= load_size_in;
        r_unsigned <= load_unsigned_in;
        r_off      <= addr_in[1:0];
        r_addr     <= {addr_in[31:2], 2'b00};
        r_wdata    <= f_store_lanes(load_size_in, store_data_in);
        r_mask     <= mem_we_in ? f_store_mask(load_size_in, addr_in[1:0]) : 4'b0000;
      end
      if (w_done && !r_we) begin
        lsu_data_out <= f_load_extract(r_size, r_unsigned, r_off, dmem.dmem_rdata_in);
      end
    end
  end

endmodule

// File: tb/tb_msrv32_lsu_bus_ctrl.sv
// Self-checking bench for msrv32_lsu_bus_ctrl: directed cases plus randomized transactions
// checked against a transaction-level reference model.
module tb_msrv32_lsu_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  load_size = 2'b00;
  logic        load_uns = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] sdata = 32'h0;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] lsu_data;
  logic        lsu_valid;
  logic        misaligned;
  logic        bus_err;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] model_last = 32'h0;
  logic        exp_valid = 1'b0;
  logic        exp_mis = 1'b0;
  logic        exp_err = 1'b0;

  msrv32_lsu_bus_ctrl_if u_if ();

  msrv32_lsu_bus_ctrl u_dut (
    .ms_risc32_mp_clk_in (clk),
    .ms_risc32_mp_rst_in (rst),
    .mem_req_in          (mem_req),
    .mem_we_in           (mem_we),
    .load_size_in        (load_size),
    .load_unsigned_in    (load_uns),
    .addr_in             (addr),
    .store_data_in       (sdata),
    .flush_in            (flush),
    .dmem                (u_if),
    .stall_out           (stall),
    .lsu_data_out        (lsu_data),
    .lsu_valid_out       (lsu_valid),
    .misaligned_out      (misaligned),
    .bus_err_out         (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on byte offsets
  function automatic bit ref_misaligned(input int size, input logic [31:0] a);
    int off = int'(a % 4);
    return (size == 1 && (off % 2) == 1) || (size >= 2 && off != 0);
  endfunction

  function automatic logic [3:0] ref_mask(input int size, input logic [31:0] a);
    int off = int'(a % 4);
    if (size == 0) return 4'(1 << off);
    if (size == 1) return 4'(3 << ((off / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input int size, input logic [31:0] d);
    if (size == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (size == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input int size, input bit uns, input logic [31:0] a,
                                           input logic [31:0] rd);
    int bits = (size == 0) ? 8 : (size == 1) ? 16 : 32;
    logic [31:0] v;
    logic [31:0] m;
    if (bits == 32) return rd;
    v = rd >> (8 * int'(a % 4));
    m = (32'h1 << bits) - 32'h1;
    v = v & m;
    if (!uns && v[bits-1]) v = v | ~m;
    return v;
  endfunction

  task automatic post_check(input string tag);
    check_eq({tag, "_valid"}, {31'h0, lsu_valid}, {31'h0, exp_valid});
    check_eq({tag, "_mis"}, {31'h0, misaligned}, {31'h0, exp_mis});
    check_eq({tag, "_err"}, {31'h0, bus_err}, {31'h0, exp_err});
    check_eq({tag, "_data"}, lsu_data, model_last);
    check_eq({tag, "_req_idle"}, {31'h0, u_if.dmem_req_out}, 32'h0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    mem_req = 1'b0; flush = 1'b0;
    u_if.dmem_ack_in = 1'($urandom_range(0, 1));
    u_if.dmem_rdata_in = $urandom;
    #1;
    post_check("idle");
    check_eq("idle_stall", {31'h0, stall}, 32'h0);
    exp_valid = 1'b0; exp_mis = 1'b0; exp_err = 1'b0;
  endtask

  // Present one request; if accepted, ack it on BUSY cycle number delay+1
  task automatic present(input bit we, input int size, input bit uns, input logic [31:0] a,
                         input logic [31:0] d, input bit fl, input int delay,
                         input logic [31:0] rd);
    bit mis = ref_misaligned(size, a);
    bit acc = !fl && !mis;
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; load_size = 2'(size); load_uns = uns;
    addr = a; sdata = d; flush = fl;
    u_if.dmem_ack_in = 1'($urandom_range(0, 1));
    u_if.dmem_rdata_in = $urandom;
    #1;
    post_check("pre");
    check_eq("accept_stall", {31'h0, stall}, {31'h0, acc});
    exp_valid = 1'b0; exp_mis = !fl && mis; exp_err = 1'b0;
    if (acc) begin
      for (int k = 0; k <= delay; k++) begin
        @(negedge clk);
        flush = 1'($urandom_range(0, 1));
        u_if.dmem_ack_in = (k == delay);
        u_if.dmem_rdata_in = (k == delay) ? rd : $urandom;
        #1;
        check_eq("busy_req", {31'h0, u_if.dmem_req_out}, 32'h1);
        check_eq("busy_addr", u_if.dmem_addr_out, a & ~32'h3);
        check_eq("busy_we", {31'h0, u_if.dmem_we_out}, {31'h0, we});
        check_eq("busy_mask", {28'h0, u_if.dmem_wr_mask_out}, {28'h0, we ? ref_mask(size, a) : 4'h0});
        if (we) check_eq("busy_wdata", u_if.dmem_wdata_out, ref_wdata(size, d));
        check_eq("busy_stall", {31'h0, stall}, {31'h0, k != delay});
        check_eq("busy_valid", {31'h0, lsu_valid}, 32'h0);
        check_eq("busy_err", {31'h0, bus_err}, 32'h0);
      end
      if (!we) model_last = ref_load(size, uns, a, rd);
      exp_valid = !we;
    end
  endtask

`ifdef MSRV32_LSU_TIMEOUT_EN
  task automatic timeout_txn();
    int n_busy = 0;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; load_size = 2'b10; load_uns = 1'b0;
    addr = 32'h400; flush = 1'b0; u_if.dmem_ack_in = 1'b0;
    #1;
    post_check("to_pre");
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      mem_req = 1'b0; u_if.dmem_ack_in = 1'b0;
      #1;
      if (!u_if.dmem_req_out) break;
      n_busy++;
      check_eq("to_stall", {31'h0, stall}, {31'h0, n_busy < 16});
    end
    check_eq("to_busy_cycles", n_busy, 16);
    check_eq("to_err_pulse", {31'h0, bus_err}, 32'h1);
    check_eq("to_no_valid", {31'h0, lsu_valid}, 32'h0);
    check_eq("to_stall_rel", {31'h0, stall}, 32'h0);
    check_eq("to_data", lsu_data, model_last);
  endtask
`endif

  initial begin
    u_if.dmem_ack_in = 1'b0;
    u_if.dmem_rdata_in = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_req", {31'h0, u_if.dmem_req_out}, 32'h0);
    check_eq("rst_addr", u_if.dmem_addr_out, 32'h0);
    check_eq("rst_mask", {28'h0, u_if.dmem_wr_mask_out}, 32'h0);
    check_eq("rst_we", {31'h0, u_if.dmem_we_out}, 32'h0);
    check_eq("rst_stall", {31'h0, stall}, 32'h0);
    post_check("rst");
    @(negedge clk);
    rst = 1'b0;

    // LB with ack on the fourth BUSY cycle
    present(1'b0, 0, 1'b0, 32'h103, 32'h0, 1'b0, 3, 32'h80FF_1234);
    idle_cycle();
    check_eq("lb_value", lsu_data, 32'hFFFF_FF80);
    present(1'b0, 1, 1'b1, 32'h202, 32'h0, 1'b0, 1, 32'h9ABC_5678);
    idle_cycle();
    check_eq("lhu_value", lsu_data, 32'h0000_9ABC);
    present(1'b0, 2, 1'b0, 32'h300, 32'h0, 1'b0, 0, 32'h9ABC_5678);
    idle_cycle();
    check_eq("lw_value", lsu_data, 32'h9ABC_5678);
    present(1'b1, 0, 1'b0, 32'h11, 32'h0000_00A5, 1'b0, 2, 32'h0);
    idle_cycle();
    check_eq("sb_keeps_data", lsu_data, 32'h9ABC_5678);
    present(1'b0, 2, 1'b0, 32'h102, 32'h0, 1'b0, 0, 32'h0);
    idle_cycle();
    idle_cycle();
    present(1'b0, 2, 1'b0, 32'h102, 32'h0, 1'b1, 0, 32'h0);
    idle_cycle();
    // Back-to-back SW then LW with no idle gap
    present(1'b1, 2, 1'b0, 32'h500, 32'hDEAD_BEEF, 1'b0, 0, 32'h0);
    present(1'b0, 2, 1'b0, 32'h504, 32'h0, 1'b0, 1, 32'h1357_9BDF);
    idle_cycle();
    // Ack arriving on the sixteenth BUSY cycle completes normally
    present(1'b0, 0, 1'b1, 32'h601, 32'h0, 1'b0, 15, 32'h0000_C300);
    idle_cycle();
`ifdef MSRV32_LSU_TIMEOUT_EN
    timeout_txn();
    exp_valid = 1'b0; exp_mis = 1'b0; exp_err = 1'b0;
    idle_cycle();
`else
    present(1'b0, 2, 1'b0, 32'h700, 32'h0, 1'b0, 20, 32'h2468_ACE0);
    idle_cycle();
`endif

    // Reset in the middle of a BUSY transaction
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; load_size = 2'b10; addr = 32'h800; flush = 1'b0;
    u_if.dmem_ack_in = 1'b0;
    #1;
    post_check("mid_pre");
    @(negedge clk);
    mem_req = 1'b0;
    #1;
    check_eq("mid_req_busy", {31'h0, u_if.dmem_req_out}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_req", {31'h0, u_if.dmem_req_out}, 32'h0);
    check_eq("mid_rst_stall", {31'h0, stall}, 32'h0);
    check_eq("mid_rst_data", lsu_data, 32'h0);
    check_eq("mid_rst_mask", {28'h0, u_if.dmem_wr_mask_out}, 32'h0);
    check_eq("mid_rst_addr", u_if.dmem_addr_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_last = 32'h0; exp_valid = 1'b0; exp_mis = 1'b0; exp_err = 1'b0;
    idle_cycle();

    // Randomized transactions
    for (int t = 0; t < 300; t++) begin
      logic [31:0] ra;
      ra = $urandom;
      present(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ra, $urandom, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 4)), $urandom);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
